payload_engine_ctrl: RTL and testbench
======================================

Name: payload_engine_ctrl

Overview:
- Sequencer for a bank of NUM_ENG regex NFA engines in the payload engine.
- Accepts one payload byte per cycle from the packet parser.
- For each packet it clears the engines (sod), streams the bytes with en, drains the engine pipeline, latches the sticky match vector, and hands one result per packet downstream.
- Sits between the packet parser and the rule-result aggregator; shared character decode sits after eng_byte.

Parameters:
- NUM_ENG, 64, number of engines in the bank (width of eng_match/res_match).
- DRAIN_CYC, 3, cycles waited after the last byte before sampling eng_match (decode + state FF + end-state FF).
- LEN_W, 16, packet length counter width.
- TIMEOUT, 1024, idle-stall cycles before forced packet close (optional feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- in_data  in  8  payload byte
- in_valid  in  1  byte valid
- in_sop  in  1  first byte of packet (qualified by in_valid)
- in_eop  in  1  last byte of packet (qualified by in_valid)
- in_ready  out  1  byte accepted when in_valid & in_ready
- eng_byte  out  8  registered byte to char decoder
- eng_en  out  1  engine advance enable
- eng_sod  out  1  engine clear (start of data)
- eng_match  in  NUM_ENG  engine out bits (sticky)
- res_valid  out  1  result valid
- res_ready  in  1  result consumed when res_valid & res_ready
- res_match  out  NUM_ENG  latched match vector
- res_len  out  LEN_W  bytes in packet, saturating
- res_err  out  1  protocol error seen in packet

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - State goes to IDLE.
  - in_ready, eng_en, res_valid, res_err go to 0; eng_byte, res_match, res_len go to 0.
  - eng_sod goes to 1 so the engines are held clear.
  - Reset mid-packet discards the packet; no result is produced.
- FSM states: IDLE, CLEAR, STREAM, DRAIN, REPORT.
- IDLE:
  - in_ready=0; eng_sod=0.
  - in_valid & in_sop seen: go to CLEAR (the byte is not consumed).
  - in_valid without in_sop: the byte is consumed and dropped (in_ready=1 for that cycle), and a sticky error flag is set for the next packet.
- CLEAR:
  - eng_sod=1 for exactly one cycle; the length counter is cleared; go to STREAM.
- STREAM:
  - in_ready=1.
  - On an accepted byte: eng_byte<=in_data and eng_en<=1 on the next cycle (latency 1); the length counter increments, saturating at all-ones.
  - No accepted byte: eng_en<=0, and the engines hold their state.
  - Accepted byte with in_eop: go to DRAIN (a single-byte packet has sop and eop on the same beat).
  - in_sop on a non-first byte: treated as data, and the error flag is set.
- DRAIN:
  - in_ready=0; eng_en=0 after the final byte's cycle.
  - A counter runs DRAIN_CYC cycles.
  - On expiry: res_match<=eng_match, res_len<=count, res_err<=flag, res_valid<=1; go to REPORT.
- REPORT:
  - res_valid is held with stable data until res_ready.
  - On the handshake: res_valid<=0, the error flag is cleared, go to IDLE.
  - res_ready already high on entry: handshake completes in that cycle.
  - The next packet's CLEAR never overlaps REPORT, so engines are never cleared before their result is latched.
- Throughput: a packet of N bytes with continuous valid and immediate res_ready occupies N + DRAIN_CYC + 3 cycles.
- res_ready while res_valid=0 is ignored.

Optional Feature:
- Macro PE_CTRL_TIMEOUT_EN.
- With the macro:
  - In STREAM, a stall counter counts consecutive cycles without an accepted byte and resets on each accepted byte.
  - Reaching TIMEOUT forces DRAIN with res_err=1.
  - The remaining bytes of that packet, up to and including eop, are then dropped in IDLE (in_ready=1) without setting the error flag for the next packet.
- Without the macro: STREAM waits indefinitely and no stall counter exists.

Decomposition:
- Shared package pe_ctrl_pkg holds:
  - the FSM state encoding (enum, 3 bits);
  - default constants NUM_ENG, DRAIN_CYC, LEN_W, TIMEOUT;
  - the result struct {match, len, err}.
- One natural sub-module, pe_ctrl_res_reg: the result holding register with its valid/ready handshake. The FSM and counters stay in the top.

Test Plan:
- 5-byte packet "/cfg/" (sop on byte 0, eop on byte 4), continuous valid, res_ready=1 -> eng_sod pulse 1 cycle; eng_en high 5 consecutive cycles, each one cycle after acceptance; res_valid 1 cycle with res_len=5, res_err=0, res_match equal to eng_match sampled DRAIN_CYC=3 cycles after the last byte.
- Single-byte packet, sop=eop=1, in_data=0x41 -> one eng_en cycle; res_len=1.
- res_ready held 0 for 10 cycles in REPORT -> res_valid and res_match stable; in_ready=0 throughout; next packet's eng_sod only after the handshake.
- Second sop mid-packet at byte 3 of 8 -> byte still streamed; res_len=8, res_err=1.
- rst_n low for 1 cycle during STREAM at byte 4 -> eng_sod=1, res_valid=0, in_ready=0 next cycle; next packet reports res_len counted from its own sop only.
- PE_CTRL_TIMEOUT_EN with TIMEOUT=16: 3 bytes then valid=0 for 16 cycles -> res_valid with res_len=3, res_err=1; trailing bytes through eop dropped; following packet has res_err=0.

Source files
------------

// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the payload engine controller.
//   - state_e : FSM state encoding (3 bits)
//   - NUM_ENG, DRAIN_CYC, LEN_W, TIMEOUT : default configuration constants
//   - res_t   : one packet result {match, len, err} at the default widths
package pe_ctrl_pkg;

    localparam int NUM_ENG   = 64;
    localparam int DRAIN_CYC = 3;
    localparam int LEN_W     = 16;
    localparam int TIMEOUT   = 1024;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_STREAM = 3'd2,
        S_DRAIN  = 3'd3,
        S_REPORT = 3'd4
    } state_e;

    typedef struct packed {
        logic [NUM_ENG-1:0] match;
        logic [LEN_W-1:0]   len;
        logic               err;
    } res_t;

endpackage

// File: rtl/pe_ctrl_res_reg.sv
// Result holding register for the payload engine controller.
// Captures one packet result on load_i and presents it with res_valid until
// the downstream aggregator accepts it (res_valid & res_ready).
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   load_i          : capture match_i/len_i/err_i and raise res_valid
//   match_i/len_i/err_i : result being captured
//   res_ready       : downstream accept
//   res_valid/res_match/res_len/res_err : held result
//   hs_o            : handshake completes this cycle
module pe_ctrl_res_reg #(
    parameter int NUM_ENG = pe_ctrl_pkg::NUM_ENG,
    parameter int LEN_W   = pe_ctrl_pkg::LEN_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic [NUM_ENG-1:0] match_i,
    input  logic [LEN_W-1:0]   len_i,
    input  logic               err_i,
    input  logic               res_ready,
    output logic               res_valid,
    output logic [NUM_ENG-1:0] res_match,
    output logic [LEN_W-1:0]   res_len,
    output logic               res_err,
    output logic               hs_o
);

    logic               valid_q;
    logic [NUM_ENG-1:0] match_q;
    logic [LEN_W-1:0]   len_q;
    logic               err_q;

    assign hs_o = valid_q & res_ready;

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            match_q <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else if (load_i && !valid_q) begin
            valid_q <= 1'b1;
            match_q <= match_i;
            len_q   <= len_i;
            err_q   <= err_i;
        end else if (hs_o) begin
            valid_q <= 1'b0;
        end
    end

    assign res_valid = valid_q;
    assign res_match = match_q;
    assign res_len   = len_q;
    assign res_err   = err_q;

endmodule

// File: rtl/payload_engine_ctrl.sv
// Payload engine controller: sequences a bank of NUM_ENG regex NFA engines.
// Per packet: clear engines (eng_sod), stream bytes (eng_byte/eng_en), wait
// DRAIN_CYC cycles for the engine pipeline, latch eng_match and hand one
// result downstream.
// Ports:
//   clk, rst_n                         : clock, synchronous active-low reset
//   in_data/in_valid/in_sop/in_eop     : payload byte stream from the parser
//   in_ready                           : byte accepted when in_valid & in_ready
//   eng_byte/eng_en/eng_sod            : engine bank controls (registered)
//   eng_match                          : sticky engine match bits
//   res_valid/res_ready                : result handshake
//   res_match/res_len/res_err          : packet result
// Optional feature: define PE_CTRL_TIMEOUT_EN to close a packet after TIMEOUT
// stalled cycles in STREAM (result flagged as error, remainder dropped).
module payload_engine_ctrl #(
    parameter int NUM_ENG   = pe_ctrl_pkg::NUM_ENG,
    parameter int DRAIN_CYC = pe_ctrl_pkg::DRAIN_CYC,
    parameter int LEN_W     = pe_ctrl_pkg::LEN_W
`ifdef PE_CTRL_TIMEOUT_EN
    ,
    parameter int TIMEOUT   = pe_ctrl_pkg::TIMEOUT
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               in_sop,
    input  logic               in_eop,
    output logic               in_ready,
    output logic [7:0]         eng_byte,
    output logic               eng_en,
    output logic               eng_sod,
    input  logic [NUM_ENG-1:0] eng_match,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [NUM_ENG-1:0] res_match,
    output logic [LEN_W-1:0]   res_len,
    output logic               res_err
);
    import pe_ctrl_pkg::*;

    localparam int DCNT_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    state_e            state_q;
    logic              in_ready_q;
    logic              eng_en_q;
    logic              eng_sod_q;
    logic [7:0]        eng_byte_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  len_d;
    logic [DCNT_W-1:0] drain_q;
    logic              err_q;
    logic              accept;
    logic              idle_take;
    logic              drain_done;
    logic              res_hs;

`ifdef PE_CTRL_TIMEOUT_EN
    localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [STALL_W-1:0] stall_q;
    logic               drop_q;
`endif

    // Stray bytes in IDLE are swallowed in the same cycle they appear, so that
    // part of in_ready is combinational; the STREAM part is registered.
    assign idle_take  = (state_q == S_IDLE) && in_valid && !in_sop;
    assign in_ready   = in_ready_q || idle_take;
    assign accept     = in_valid && in_ready_q;
    assign len_d      = (&len_q) ? len_q : len_q + 1'b1;
    assign drain_done = (state_q == S_DRAIN) && (drain_q == DCNT_W'(DRAIN_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            in_ready_q <= 1'b0;
            eng_en_q   <= 1'b0;
            eng_sod_q  <= 1'b1;   // engines held clear while in reset
            eng_byte_q <= '0;
            len_q      <= '0;
            drain_q    <= '0;
            err_q      <= 1'b0;
`ifdef PE_CTRL_TIMEOUT_EN
            stall_q    <= '0;
            drop_q     <= 1'b0;
`endif
        end else begin
            eng_en_q  <= 1'b0;
            eng_sod_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (in_valid && in_sop) begin
                        state_q   <= S_CLEAR;
                        eng_sod_q <= 1'b1;
`ifdef PE_CTRL_TIMEOUT_EN
                        drop_q    <= 1'b0;
`endif
                    end else if (in_valid) begin
`ifdef PE_CTRL_TIMEOUT_EN
                        // Tail of a timed-out packet is dropped silently.
                        if (drop_q) begin
                            if (in_eop) drop_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
`else
                        err_q <= 1'b1;
`endif
                    end
                end
                S_CLEAR: begin
                    len_q      <= '0;
                    in_ready_q <= 1'b1;
                    state_q    <= S_STREAM;
`ifdef PE_CTRL_TIMEOUT_EN
                    stall_q    <= '0;
`endif
                end
                S_STREAM: begin
                    if (accept) begin
                        eng_byte_q <= in_data;
                        eng_en_q   <= 1'b1;
                        len_q      <= len_d;
                        // len_q is zero only before the packet's first byte.
                        if (in_sop && (len_q != '0)) err_q <= 1'b1;
                        if (in_eop) begin
                            in_ready_q <= 1'b0;
                            drain_q    <= '0;
                            state_q    <= S_DRAIN;
                        end
`ifdef PE_CTRL_TIMEOUT_EN
                        stall_q <= '0;
                    end else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                        in_ready_q <= 1'b0;
                        drain_q    <= '0;
                        err_q      <= 1'b1;
                        drop_q     <= 1'b1;
                        state_q    <= S_DRAIN;
                    end else begin
                        stall_q <= stall_q + 1'b1;
`endif
                    end
                end
                S_DRAIN: begin
                    if (drain_done) state_q <= S_REPORT;
                    else            drain_q <= drain_q + 1'b1;
                end
                S_REPORT: begin
                    if (res_hs) begin
                        err_q   <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    pe_ctrl_res_reg #(
        .NUM_ENG (NUM_ENG),
        .LEN_W   (LEN_W)
    ) u_res_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (drain_done),
        .match_i   (eng_match),
        .len_i     (len_q),
        .err_i     (err_q),
        .res_ready (res_ready),
        .res_valid (res_valid),
        .res_match (res_match),
        .res_len   (res_len),
        .res_err   (res_err),
        .hs_o      (res_hs)
    );

    assign eng_byte = eng_byte_q;
    assign eng_en   = eng_en_q;
    assign eng_sod  = eng_sod_q;

endmodule

// File: tb/tb_payload_engine_ctrl.sv
// Directed self-checking bench for payload_engine_ctrl.
module tb_payload_engine_ctrl;
    import pe_ctrl_pkg::*;

    localparam int T_NUM_ENG = 64;
    localparam int T_DRAIN   = 3;
    localparam int T_LEN_W   = 16;
`ifdef PE_CTRL_TIMEOUT_EN
    localparam int T_TIMEOUT = 16;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [7:0]           in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_sop = 1'b0;
    logic                 in_eop = 1'b0;
    logic                 in_ready;
    logic [7:0]           eng_byte;
    logic                 eng_en;
    logic                 eng_sod;
    logic [T_NUM_ENG-1:0] eng_match;
    logic                 res_valid;
    logic                 res_ready = 1'b1;
    logic [T_NUM_ENG-1:0] res_match;
    logic [T_LEN_W-1:0]   res_len;
    logic                 res_err;

    int tests_run = 0;
    int failed = 0;

    payload_engine_ctrl #(
        .NUM_ENG   (T_NUM_ENG),
        .DRAIN_CYC (T_DRAIN),
        .LEN_W     (T_LEN_W)
`ifdef PE_CTRL_TIMEOUT_EN
        ,
        .TIMEOUT   (T_TIMEOUT)
`endif
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .in_ready  (in_ready),
        .eng_byte  (eng_byte),
        .eng_en    (eng_en),
        .eng_sod   (eng_sod),
        .eng_match (eng_match),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_match (res_match),
        .res_len   (res_len),
        .res_err   (res_err)
    );

    always #5 clk = ~clk;

    // Cycle number; eng_match carries a distinct pattern every cycle so the
    // latched vector identifies exactly which cycle was sampled.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pat(input int k);
        return {32'(k) * 32'h9E3779B1, ~32'(k)};
    endfunction

    assign eng_match = pat(cyc);

    // ---------------- monitor (sampled on the falling edge) ----------------
    int         sod_cnt = 0, en_cnt = 0, rv_cnt = 0, hs_cnt = 0, lat_err = 0;
    int         last_acc = 0, hs_cyc = 0, sod_cyc = 0;
    logic [7:0] en_log [0:1023];
    bit         prev_acc = 0;
    logic [7:0] prev_data = '0;
    bit         expect_stream = 0;
    res_t       got;

    always @(negedge clk) begin
        if (rst_n) begin
            if (eng_sod === 1'b1) begin sod_cnt++; sod_cyc = cyc; end
            if (eng_en === 1'b1) begin en_log[en_cnt % 1024] = eng_byte; en_cnt++; end
            // eng_en must follow each streamed acceptance by exactly one cycle.
            if ((eng_en !== prev_acc) || (prev_acc && (eng_byte !== prev_data))) lat_err++;
            prev_acc  = (in_valid && in_ready === 1'b1 && expect_stream);
            prev_data = in_data;
            if (prev_acc) last_acc = cyc;
            if (res_valid === 1'b1) begin
                rv_cnt++;
                if (res_ready) begin
                    hs_cnt++;
                    hs_cyc    = cyc;
                    got.match = res_match;
                    got.len   = res_len;
                    got.err   = res_err;
                end
            end
        end else begin
            prev_acc = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] pkt [0:15];

    task automatic send_pkt(input int n, input int sop2, input int nsend, output int c0);
        bit took;
        int w;
        c0 = cyc;
        expect_stream = 1;
        for (int i = 0; i < nsend; i++) begin
            in_valid = 1'b1;
            in_data  = pkt[i];
            in_sop   = (i == 0) || (i == sop2);
            in_eop   = (i == n - 1);
            took = 0;
            w = 0;
            while (!took && w < 64) begin
                @(negedge clk);
                took = (in_ready === 1'b1);
                @(posedge clk); #1;
                w++;
            end
            tests_run++;
            if (!took) begin
                failed++;
                $display("FAIL send_byte_%0d: accepted=0 required=1 within 64 cycles", i);
            end
        end
        in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
        expect_stream = 0;
    endtask

    task automatic wait_result(input int base, input string tag);
        int w = 0;
        while (hs_cnt == base && w < 200) begin @(posedge clk); #1; w++; end
        tests_run++;
        if (hs_cnt == base) begin
            failed++;
            $display("FAIL %s_result: handshake=0 required=1 within 200 cycles", tag);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({in_ready, eng_en, res_valid, res_err} !== 4'b0000) begin
            failed++;
            $display("FAIL reset_ctrl: ready/en/valid/err=%b required=0000",
                     {in_ready, eng_en, res_valid, res_err});
        end
        tests_run++;
        if (eng_sod !== 1'b1) begin
            failed++;
            $display("FAIL reset_sod: eng_sod=%b required=1", eng_sod);
        end
        tests_run++;
        if (eng_byte !== 8'h00 || res_match !== 64'h0 || res_len !== 16'h0) begin
            failed++;
            $display("FAIL reset_data: byte=%h match=%h len=%0d required 0/0/0",
                     eng_byte, res_match, res_len);
        end
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if (eng_sod !== 1'b0 || in_ready !== 1'b0) begin
            failed++;
            $display("FAIL idle_after_reset: sod=%b ready=%b required 0/0", eng_sod, in_ready);
        end
    endtask

    task automatic test_basic_packet();
        int b_sod, b_en, b_rv, b_hs, b_lat, c0;
        res_t exp;
        pkt[0] = 8'h2F; pkt[1] = 8'h63; pkt[2] = 8'h66; pkt[3] = 8'h67; pkt[4] = 8'h2F;
        b_sod = sod_cnt; b_en = en_cnt; b_rv = rv_cnt; b_hs = hs_cnt; b_lat = lat_err;
        send_pkt(5, -1, 5, c0);
        wait_result(b_hs, "basic");
        exp.match = pat(last_acc + T_DRAIN);
        exp.len   = 16'd5;
        exp.err   = 1'b0;
        tests_run++;
        if (sod_cnt - b_sod != 1) begin
            failed++; $display("FAIL basic_sod_cycles: got=%0d required=1", sod_cnt - b_sod);
        end
        tests_run++;
        if (en_cnt - b_en != 5 || lat_err != b_lat) begin
            failed++;
            $display("FAIL basic_en: en_cycles=%0d latency_errors=%0d required 5/0",
                     en_cnt - b_en, lat_err - b_lat);
        end
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if (en_log[(b_en + i) % 1024] !== pkt[i]) begin
                failed++;
                $display("FAIL basic_byte_%0d: eng_byte=%h required=%h", i,
                         en_log[(b_en + i) % 1024], pkt[i]);
            end
        end
        tests_run++;
        if (rv_cnt - b_rv != 1) begin
            failed++; $display("FAIL basic_valid_cycles: got=%0d required=1", rv_cnt - b_rv);
        end
        tests_run++;
        if (got !== exp) begin
            failed++;
            $display("FAIL basic_result: match=%h len=%0d err=%b required match=%h len=%0d err=%b",
                     got.match, got.len, got.err, exp.match, exp.len, exp.err);
        end
        tests_run++;
        if (hs_cyc - c0 != 5 + T_DRAIN + 2) begin
            failed++;
            $display("FAIL basic_throughput: cycles=%0d required=%0d", hs_cyc - c0 + 1, 5 + T_DRAIN + 3);
        end
    endtask

    task automatic test_single_byte();
        int b_en, b_hs, c0;
        pkt[0] = 8'h41;
        b_en = en_cnt; b_hs = hs_cnt;
        send_pkt(1, -1, 1, c0);
        wait_result(b_hs, "single");
        tests_run++;
        if (en_cnt - b_en != 1 || en_log[b_en % 1024] !== 8'h41) begin
            failed++;
            $display("FAIL single_en: en_cycles=%0d byte=%h required 1/41",
                     en_cnt - b_en, en_log[b_en % 1024]);
        end
        tests_run++;
        if (got.len !== 16'd1 || got.err !== 1'b0) begin
            failed++;
            $display("FAIL single_result: len=%0d err=%b required 1/0", got.len, got.err);
        end
    endtask

    task automatic test_backpressure();
        int b_hs, b_sod, c0, w, blocked_hs;
        logic [63:0] held;
        for (int i = 0; i < 4; i++) pkt[i] = 8'h30 + 8'(i);
        res_ready = 1'b0;
        b_hs = hs_cnt;
        send_pkt(4, -1, 4, c0);
        w = 0;
        while (res_valid !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
        tests_run++;
        if (res_valid !== 1'b1) begin
            failed++; $display("FAIL bp_valid: res_valid=%b required=1", res_valid);
        end
        held = res_match;
        // Next packet's sop waits at the input while the result is held.
        in_valid = 1'b1; in_sop = 1'b1; in_data = 8'h50;
        b_sod = sod_cnt;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            tests_run++;
            if (res_valid !== 1'b1 || res_match !== held || in_ready !== 1'b0) begin
                failed++;
                $display("FAIL bp_hold_%0d: valid=%b match=%h ready=%b required 1/%h/0",
                         i, res_valid, res_match, in_ready, held);
            end
        end
        tests_run++;
        if (sod_cnt != b_sod) begin
            failed++; $display("FAIL bp_sod_during_hold: got=%0d required=0", sod_cnt - b_sod);
        end
        res_ready = 1'b1;
        wait_result(b_hs, "bp");
        blocked_hs = hs_cyc;
        tests_run++;
        if (got.len !== 16'd4 || got.match !== held) begin
            failed++;
            $display("FAIL bp_result: len=%0d match=%h required 4/%h", got.len, got.match, held);
        end
        pkt[0] = 8'h50; pkt[1] = 8'h51;
        b_hs = hs_cnt;
        send_pkt(2, -1, 2, c0);
        wait_result(b_hs, "bp_next");
        tests_run++;
        if (sod_cyc <= blocked_hs) begin
            failed++;
            $display("FAIL bp_sod_order: sod_cycle=%0d required after handshake cycle %0d",
                     sod_cyc, blocked_hs);
        end
    endtask

    task automatic test_mid_sop();
        int b_en, b_hs, c0;
        for (int i = 0; i < 8; i++) pkt[i] = 8'h60 + 8'(i);
        b_en = en_cnt; b_hs = hs_cnt;
        send_pkt(8, 3, 8, c0);
        wait_result(b_hs, "midsop");
        tests_run++;
        if (en_cnt - b_en != 8 || got.len !== 16'd8 || got.err !== 1'b1) begin
            failed++;
            $display("FAIL midsop_result: en=%0d len=%0d err=%b required 8/8/1",
                     en_cnt - b_en, got.len, got.err);
        end
        b_hs = hs_cnt;
        send_pkt(3, -1, 3, c0);
        wait_result(b_hs, "midsop_next");
        tests_run++;
        if (got.len !== 16'd3 || got.err !== 1'b0) begin
            failed++;
            $display("FAIL midsop_next: len=%0d err=%b required 3/0", got.len, got.err);
        end
    endtask

    task automatic test_reset_mid_packet();
        int b_hs, b_rv, c0;
        for (int i = 0; i < 8; i++) pkt[i] = 8'h70 + 8'(i);
        b_hs = hs_cnt; b_rv = rv_cnt;
        send_pkt(8, -1, 4, c0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (eng_sod !== 1'b1 || res_valid !== 1'b0 || in_ready !== 1'b0) begin
            failed++;
            $display("FAIL rst_mid: sod=%b valid=%b ready=%b required 1/0/0",
                     eng_sod, res_valid, in_ready);
        end
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        tests_run++;
        if (hs_cnt != b_hs || rv_cnt != b_rv) begin
            failed++;
            $display("FAIL rst_mid_no_result: results=%0d required=0", rv_cnt - b_rv);
        end
        b_hs = hs_cnt;
        send_pkt(6, -1, 6, c0);
        wait_result(b_hs, "rst_next");
        tests_run++;
        if (got.len !== 16'd6 || got.err !== 1'b0) begin
            failed++;
            $display("FAIL rst_next_result: len=%0d err=%b required 6/0", got.len, got.err);
        end
    endtask

    task automatic test_stray_byte();
        int b_hs, b_en, c0;
        bit r;
        b_en = en_cnt;
        in_valid = 1'b1; in_sop = 1'b0; in_data = 8'h55;
        @(negedge clk);
        r = (in_ready === 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests_run++;
        if (!r || en_cnt != b_en) begin
            failed++;
            $display("FAIL stray_drop: ready=%b en_cycles=%0d required 1/0", r, en_cnt - b_en);
        end
        pkt[0] = 8'h01; pkt[1] = 8'h02;
        b_hs = hs_cnt;
        send_pkt(2, -1, 2, c0);
        wait_result(b_hs, "stray");
        tests_run++;
        if (got.len !== 16'd2 || got.err !== 1'b1) begin
            failed++;
            $display("FAIL stray_result: len=%0d err=%b required 2/1", got.len, got.err);
        end
    endtask

`ifdef PE_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int b_hs, b_en, b_sod, c0, taken;
        bit r;
        for (int i = 0; i < 6; i++) pkt[i] = 8'h80 + 8'(i);
        b_hs = hs_cnt;
        send_pkt(6, -1, 3, c0);
        wait_result(b_hs, "timeout");
        tests_run++;
        if (got.len !== 16'd3 || got.err !== 1'b1) begin
            failed++;
            $display("FAIL timeout_result: len=%0d err=%b required 3/1", got.len, got.err);
        end
        tests_run++;
        if (hs_cyc != last_acc + T_TIMEOUT + T_DRAIN + 1) begin
            failed++;
            $display("FAIL timeout_timing: handshake_cycle=%0d required=%0d",
                     hs_cyc, last_acc + T_TIMEOUT + T_DRAIN + 1);
        end
        b_en = en_cnt; b_sod = sod_cnt; taken = 0;
        for (int i = 3; i < 6; i++) begin
            in_valid = 1'b1; in_sop = 1'b0; in_eop = (i == 5); in_data = pkt[i];
            @(negedge clk);
            r = (in_ready === 1'b1);
            if (r) taken++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_eop = 1'b0;
        tests_run++;
        if (taken != 3 || en_cnt != b_en || sod_cnt != b_sod) begin
            failed++;
            $display("FAIL timeout_drop: taken=%0d en=%0d sod=%0d required 3/0/0",
                     taken, en_cnt - b_en, sod_cnt - b_sod);
        end
        pkt[0] = 8'h90; pkt[1] = 8'h91;
        b_hs = hs_cnt;
        send_pkt(2, -1, 2, c0);
        wait_result(b_hs, "timeout_next");
        tests_run++;
        if (got.len !== 16'd2 || got.err !== 1'b0) begin
            failed++;
            $display("FAIL timeout_next: len=%0d err=%b required 2/0", got.len, got.err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_packet();
        test_single_byte();
        test_backpressure();
        test_mid_sop();
        test_reset_mid_packet();
        test_stray_byte();
`ifdef PE_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
